// File: rtl/cmd_stream_initiator_if.sv
// -----------------------------------------------------------------------------
// cmd_stream_initiator_if
//
// Bundles every handshake/bus signal of cmd_stream_initiator so the block can be
// dropped next to a sequencer, a command_processor and a response sink with a
// single connection. Signal names match the original flat port list.
//
//   Command side   : cmd_valid, cmd_ready, cmd_data[63:0], cmd_expect
//   Byte stream    : m_tvalid, m_tready, m_tdata[7:0]          (to command_processor)
//   Response in    : s_tvalid, s_tready, s_tdata[31:0], s_tkeep[3:0], s_tlast
//   Response out   : rsp_valid, rsp_ready, rsp_data[31:0], rsp_keep[3:0], rsp_last
//   Status         : busy, timeout, word_count[15:0]
//
// modport master : the initiator itself.
// modport slave  : the environment around it (sequencer, processor, sink).
// -----------------------------------------------------------------------------
interface cmd_stream_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic        cmd_expect;

    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;

    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_keep;
    logic        rsp_last;

    logic        busy;
    logic        timeout;
    logic [15:0] word_count;

    modport master (
        input  cmd_valid, cmd_data, cmd_expect,
        input  m_tready,
        input  s_tvalid, s_tdata, s_tkeep, s_tlast,
        input  rsp_ready,
        output cmd_ready,
        output m_tvalid, m_tdata,
        output s_tready,
        output rsp_valid, rsp_data, rsp_keep, rsp_last,
        output busy, timeout, word_count
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_expect,
        output m_tready,
        output s_tvalid, s_tdata, s_tkeep, s_tlast,
        output rsp_ready,
        input  cmd_ready,
        input  m_tvalid, m_tdata,
        input  s_tready,
        input  rsp_valid, rsp_data, rsp_keep, rsp_last,
        input  busy, timeout, word_count
    );
endinterface

// File: rtl/cmd_stream_initiator.sv
// -----------------------------------------------------------------------------
// cmd_stream_initiator
//
// Takes a 64-bit command word, sends it as eight bytes (byte 0 = opcode first)
// on an 8-bit stream master, then optionally collects the 32-bit response
// stream and forwards each word through a one-entry registered output port.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - cmd_stream_initiator_if.master (command, byte stream, response
//          stream in/out, busy/timeout/word_count status)
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles tolerated on either stream before the command
//                    is aborted with a one-cycle timeout pulse (2..2^24-1).
// -----------------------------------------------------------------------------
module cmd_stream_initiator #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input logic                    clk,
    input logic                    rst,
    cmd_stream_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV
    } state_t;

    // Abort fires on the idle cycle whose increment would bring the counter to
    // TIMEOUT_CYCLES-1.
    localparam logic [23:0] TMO_FIRE = TIMEOUT_CYCLES - 24'd2;

    state_t      state_q;
    logic [63:0] cmd_q;
    logic        expect_q;
    logic [2:0]  byte_idx_q;
    logic [23:0] tmo_cnt_q;
    logic [15:0] word_count_q;

    logic        cmd_ready_q;
    logic        m_tvalid_q;
    logic        busy_q;
    logic        timeout_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [3:0]  rsp_keep_q;
    logic        rsp_last_q;

    logic        s_tready_c;
    logic        byte_fire;
    logic        word_fire;
    logic        tmo_hit;

    // Response input is open whenever the output register is empty or is being
    // drained this same cycle.
    assign s_tready_c = (state_q == RECV) && (!rsp_valid_q || bus.rsp_ready);
    assign byte_fire  = m_tvalid_q && bus.m_tready;
    assign word_fire  = bus.s_tvalid && s_tready_c;
    assign tmo_hit    = (tmo_cnt_q == TMO_FIRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            expect_q     <= 1'b0;
            byte_idx_q   <= '0;
            tmo_cnt_q    <= '0;
            word_count_q <= '0;
            cmd_ready_q  <= 1'b0;
            m_tvalid_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_keep_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;

            // Output register runs independently of the FSM so a word still
            // held after returning to IDLE drains normally.
            if (word_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.s_tdata;
                rsp_keep_q  <= bus.s_tkeep;
                rsp_last_q  <= bus.s_tlast;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_q        <= bus.cmd_data;
                        expect_q     <= bus.cmd_expect;
                        byte_idx_q   <= '0;
                        word_count_q <= '0;
                        tmo_cnt_q    <= '0;
                        state_q      <= SEND;
                        cmd_ready_q  <= 1'b0;
                        m_tvalid_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                SEND: begin
                    if (byte_fire) begin
                        // cmd_q is a shift register: the byte on the wire is
                        // always cmd_q[7:0], so it cannot change until taken.
                        cmd_q      <= {8'h00, cmd_q[63:8]};
                        byte_idx_q <= byte_idx_q + 3'd1;
                        tmo_cnt_q  <= '0;
                        if (byte_idx_q == 3'd7) begin
                            m_tvalid_q <= 1'b0;
                            if (expect_q) begin
                                state_q <= RECV;
                            end else begin
                                state_q     <= IDLE;
                                cmd_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q     <= IDLE;
                        cmd_q       <= '0;
                        byte_idx_q  <= '0;
                        tmo_cnt_q   <= '0;
                        m_tvalid_q  <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                    end
                end

                RECV: begin
                    if (word_fire) begin
                        tmo_cnt_q <= '0;
                        if ((bus.s_tkeep != 4'b0000) && (word_count_q != 16'hFFFF)) begin
                            word_count_q <= word_count_q + 16'd1;
                        end
                        if (bus.s_tlast) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state_q     <= IDLE;
                        tmo_cnt_q   <= '0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    m_tvalid_q  <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.m_tvalid   = m_tvalid_q;
    assign bus.m_tdata    = cmd_q[7:0];
    assign bus.s_tready   = s_tready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_keep   = rsp_keep_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.busy       = busy_q;
    assign bus.timeout    = timeout_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_cmd_stream_initiator.sv
// -----------------------------------------------------------------------------
// tb_cmd_stream_initiator
//
// Two initiators share clk/rst: dut_a (TIMEOUT_CYCLES=64) for the functional
// scenarios, dut_b (TIMEOUT_CYCLES=16) for the abort scenario. Expected bytes
// are queued when a command is issued; expected response words are queued when
// the responder's word is taken, and both are compared in order as the DUT
// produces them.
// -----------------------------------------------------------------------------
module tb_cmd_stream_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cmd_stream_initiator_if a();
    cmd_stream_initiator_if b();

    cmd_stream_initiator #(.TIMEOUT_CYCLES(24'd64)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.master)
    );

    cmd_stream_initiator #(.TIMEOUT_CYCLES(24'd16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.master)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  exp_bytes[$];
    logic [36:0] exp_rsp[$];   // {last, keep, data}

    // Issue one command on dut_a and queue its eight bytes, byte 0 first.
    task automatic send_cmd_a(input logic [63:0] data, input logic expect_rsp);
        a.cmd_valid  = 1'b1;
        a.cmd_data   = data;
        a.cmd_expect = expect_rsp;
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) exp_bytes.push_back(data[8*i +: 8]);
        @(posedge clk); #1;
        a.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [66:0] outs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {a.cmd_ready, a.m_tvalid, a.m_tdata, a.s_tready, a.rsp_valid, a.rsp_data,
                a.rsp_keep, a.rsp_last, a.busy, a.timeout, a.word_count};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a.cmd_ready, b.cmd_ready, a.busy} !== 3'b110) begin
            failures++;
            $display("FAIL post_reset_ready: got %b required 110", {a.cmd_ready, b.cmd_ready, a.busy});
        end
    endtask

    task automatic test_version_read();
        logic [36:0] plan[$];
        logic [36:0] er;
        logic [7:0]  eb;
        int unsigned nbytes, cyc;
        logic        word_prev, done;
        nbytes = 0; cyc = 0; word_prev = 1'b0; done = 1'b0;
        plan.push_back({1'b0, 4'hF, 32'h0000_0014});
        plan.push_back({1'b1, 4'h0, 32'h0000_0000});
        exp_rsp.delete();
        send_cmd_a(64'h0000_0000_0000_0002, 1'b1);
        while (!done && cyc < 100) begin
            a.m_tready  = 1'b1;
            a.rsp_ready = 1'b1;
            a.s_tvalid  = (nbytes == 8) && (plan.size() != 0);
            if (plan.size() != 0) {a.s_tlast, a.s_tkeep, a.s_tdata} = plan[0];
            #1;
            if (cyc < 8) begin
                checks++;
                if (a.m_tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL ver_m_tvalid cyc %0d: got %b required 1", cyc, a.m_tvalid);
                end
            end
            if (cyc == 7 || cyc == 8) begin
                checks++;
                if (a.s_tready !== (cyc == 8)) begin
                    failures++;
                    $display("FAIL ver_s_tready_rise cyc %0d: got %b required %b", cyc, a.s_tready, (cyc == 8));
                end
            end
            if (word_prev) begin
                checks++;
                if (a.rsp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL ver_rsp_latency: got %b required 1", a.rsp_valid);
                end
            end
            word_prev = 1'b0;
            if (a.m_tvalid && a.m_tready) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    failures++;
                    $display("FAIL ver_extra_byte: got %h required none", a.m_tdata);
                end else begin
                    eb = exp_bytes.pop_front();
                    if (a.m_tdata !== eb) begin
                        failures++;
                        $display("FAIL ver_byte %0d: got %h required %h", nbytes, a.m_tdata, eb);
                    end
                end
                nbytes++;
            end
            if (a.s_tvalid && a.s_tready) begin
                exp_rsp.push_back(plan.pop_front());
                word_prev = 1'b1;
            end
            if (a.rsp_valid && a.rsp_ready) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    failures++;
                    $display("FAIL ver_extra_rsp: got %h required none", a.rsp_data);
                end else begin
                    er = exp_rsp.pop_front();
                    if ({a.rsp_last, a.rsp_keep, a.rsp_data} !== er) begin
                        failures++;
                        $display("FAIL ver_rsp: got %h required %h", {a.rsp_last, a.rsp_keep, a.rsp_data}, er);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
            done = (nbytes == 8) && (plan.size() == 0) && (exp_rsp.size() == 0);
        end
        a.s_tvalid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ver_complete: got bytes=%0d words_left=%0d required 8/0", nbytes, plan.size());
        end
        checks++;
        if ({a.word_count, a.busy, a.cmd_ready} !== {16'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ver_status: got wc=%0d busy=%b ready=%b required 1/0/1", a.word_count, a.busy, a.cmd_ready);
        end
    endtask

    task automatic test_fire_and_forget();
        logic [7:0]  eb;
        int unsigned nbytes, cyc;
        logic        seen_s_tready;
        nbytes = 0; cyc = 0; seen_s_tready = 1'b0;
        send_cmd_a(64'h0000_0000_0000_0006, 1'b0);
        a.s_tvalid = 1'b1;   // a stray responder must never be accepted
        {a.s_tlast, a.s_tkeep, a.s_tdata} = {1'b1, 4'hF, 32'hDEAD_BEEF};
        while (nbytes < 8 && cyc < 20) begin
            a.m_tready = 1'b1;
            #1;
            if (a.s_tready) seen_s_tready = 1'b1;
            if (a.m_tvalid && a.m_tready) begin
                eb = exp_bytes.pop_front();
                checks++;
                if (a.m_tdata !== eb) begin
                    failures++;
                    $display("FAIL ff_byte %0d: got %h required %h", nbytes, a.m_tdata, eb);
                end
                nbytes++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL ff_byte_cycles: got %0d required 8", cyc);
        end
        checks++;
        if ({a.busy, a.cmd_ready, a.m_tvalid} !== 3'b010) begin
            failures++;
            $display("FAIL ff_idle_after_byte7: got busy/ready/tvalid=%b required 010", {a.busy, a.cmd_ready, a.m_tvalid});
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            if (a.s_tready) seen_s_tready = 1'b1;
            @(posedge clk); #1;
        end
        a.s_tvalid = 1'b0;
        checks++;
        if (seen_s_tready !== 1'b0) begin
            failures++;
            $display("FAIL ff_s_tready: got 1 required 0");
        end
        checks++;
        if (a.word_count !== 16'd0) begin
            failures++;
            $display("FAIL ff_word_count: got %0d required 0", a.word_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  eb, prev_data;
        int unsigned nbytes, cyc;
        logic        prev_stall;
        nbytes = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        send_cmd_a(64'h8877_6655_4433_2211, 1'b0);
        while (nbytes < 8 && cyc < 40) begin
            a.m_tready = cyc[0];
            #1;
            if (prev_stall) begin
                checks++;
                if (a.m_tdata !== prev_data) begin
                    failures++;
                    $display("FAIL bp_hold: got %h required %h", a.m_tdata, prev_data);
                end
            end
            prev_stall = a.m_tvalid && !a.m_tready;
            prev_data  = a.m_tdata;
            if (a.m_tvalid && a.m_tready) begin
                eb = exp_bytes.pop_front();
                checks++;
                if (a.m_tdata !== eb) begin
                    failures++;
                    $display("FAIL bp_byte %0d: got %h required %h", nbytes, a.m_tdata, eb);
                end
                nbytes++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a.m_tready = 1'b1;
        #1;
        checks++;
        if ({nbytes == 8, a.m_tvalid, a.busy} !== 3'b100) begin
            failures++;
            $display("FAIL bp_transfers: got bytes=%0d tvalid=%b busy=%b required 8/0/0", nbytes, a.m_tvalid, a.busy);
        end
        @(posedge clk); #1;
        a.m_tready = 1'b0;
    endtask

    task automatic test_stream_read();
        logic [36:0] plan[$];
        logic [36:0] er;
        int unsigned nbytes, nrsp, cyc, stall_left;
        logic        stall_done, done;
        nbytes = 0; nrsp = 0; cyc = 0; stall_left = 0; stall_done = 1'b0; done = 1'b0;
        for (int i = 0; i < 50; i++) plan.push_back({(i == 49), 4'hF, 32'hD000_0000 | i});
        exp_rsp.delete();
        send_cmd_a(64'h0000_0000_0000_C800, 1'b1);
        while (!done && cyc < 400) begin
            if (nrsp == 10 && !stall_done) begin
                stall_left = 20;
                stall_done = 1'b1;
            end
            a.rsp_ready = (stall_left == 0);
            if (stall_left != 0) stall_left--;
            a.m_tready = 1'b1;
            a.s_tvalid = (nbytes == 8) && (plan.size() != 0);
            if (plan.size() != 0) {a.s_tlast, a.s_tkeep, a.s_tdata} = plan[0];
            #1;
            if (a.rsp_valid && !a.rsp_ready) begin
                checks++;
                if (a.s_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL sr_s_tready_full: got %b required 0", a.s_tready);
                end
            end
            if (a.m_tvalid && a.m_tready) nbytes++;
            if (a.s_tvalid && a.s_tready) exp_rsp.push_back(plan.pop_front());
            if (a.rsp_valid && a.rsp_ready) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    failures++;
                    $display("FAIL sr_extra_rsp: got %h required none", a.rsp_data);
                end else begin
                    er = exp_rsp.pop_front();
                    if ({a.rsp_last, a.rsp_keep, a.rsp_data} !== er) begin
                        failures++;
                        $display("FAIL sr_rsp %0d: got %h required %h", nrsp, {a.rsp_last, a.rsp_keep, a.rsp_data}, er);
                    end
                end
                nrsp++;
            end
            @(posedge clk); #1;
            cyc++;
            done = (plan.size() == 0) && (exp_rsp.size() == 0);
        end
        a.s_tvalid  = 1'b0;
        a.rsp_ready = 1'b1;
        checks++;
        if (nrsp !== 50) begin
            failures++;
            $display("FAIL sr_word_total: got %0d required 50", nrsp);
        end
        checks++;
        if ({a.word_count, a.busy} !== {16'd50, 1'b0}) begin
            failures++;
            $display("FAIL sr_status: got wc=%0d busy=%b required 50/0", a.word_count, a.busy);
        end
    endtask

    task automatic test_timeout();
        int unsigned nbytes, cyc;
        nbytes = 0; cyc = 0;
        b.cmd_valid  = 1'b1;
        b.cmd_data   = 64'h0000_0000_0000_0001;
        b.cmd_expect = 1'b1;
        b.rsp_ready  = 1'b1;
        b.s_tvalid   = 1'b0;
        @(posedge clk); #1;
        b.cmd_valid = 1'b0;
        while (nbytes < 8 && cyc < 20) begin
            b.m_tready = 1'b1;
            #1;
            if (b.m_tvalid && b.m_tready) nbytes++;
            @(posedge clk); #1;
            cyc++;
        end
        b.m_tready = 1'b0;
        checks++;
        if (nbytes !== 8) begin
            failures++;
            $display("FAIL to_bytes: got %0d required 8", nbytes);
        end
        // k counts clock edges after the edge that took the last byte.
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (b.timeout !== (k == 15)) begin
                failures++;
                $display("FAIL to_pulse k=%0d: got %b required %b", k, b.timeout, (k == 15));
            end
            if (k == 14 || k == 15) begin
                checks++;
                if ({b.busy, b.cmd_ready} !== ((k == 15) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL to_state k=%0d: got busy/ready=%b required %b", k, {b.busy, b.cmd_ready},
                             ((k == 15) ? 2'b01 : 2'b10));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_send();
        logic [66:0] outs;
        logic [7:0]  eb;
        int unsigned nbytes, cyc;
        nbytes = 0; cyc = 0;
        send_cmd_a(64'h1122_3344_5566_7788, 1'b1);
        while (nbytes < 4 && cyc < 20) begin
            a.m_tready = 1'b1;
            #1;
            if (a.m_tvalid && a.m_tready) nbytes++;
            @(posedge clk); #1;
            cyc++;
        end
        a.m_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        outs = {a.cmd_ready, a.m_tvalid, a.m_tdata, a.s_tready, a.rsp_valid, a.rsp_data,
                a.rsp_keep, a.rsp_last, a.busy, a.timeout, a.word_count};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %h required 0", outs);
        end
        @(posedge clk); #1;
        checks++;
        if (a.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready: got %b required 1", a.cmd_ready);
        end
        nbytes = 0; cyc = 0;
        send_cmd_a(64'hA8A7_A6A5_A4A3_A2A1, 1'b0);
        while (nbytes < 8 && cyc < 20) begin
            a.m_tready = 1'b1;
            #1;
            if (a.m_tvalid && a.m_tready) begin
                eb = exp_bytes.pop_front();
                checks++;
                if (a.m_tdata !== eb) begin
                    failures++;
                    $display("FAIL rst_restart_byte %0d: got %h required %h", nbytes, a.m_tdata, eb);
                end
                nbytes++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a.m_tready = 1'b0;
        checks++;
        if ({nbytes == 8, a.busy} !== 2'b10) begin
            failures++;
            $display("FAIL rst_restart_done: got bytes=%0d busy=%b required 8/0", nbytes, a.busy);
        end
    endtask

    initial begin
        a.cmd_valid = 1'b0; a.cmd_data = '0; a.cmd_expect = 1'b0; a.m_tready = 1'b0;
        a.s_tvalid = 1'b0; a.s_tdata = '0; a.s_tkeep = '0; a.s_tlast = 1'b0; a.rsp_ready = 1'b1;
        b.cmd_valid = 1'b0; b.cmd_data = '0; b.cmd_expect = 1'b0; b.m_tready = 1'b0;
        b.s_tvalid = 1'b0; b.s_tdata = '0; b.s_tkeep = '0; b.s_tlast = 1'b0; b.rsp_ready = 1'b1;

        test_reset();
        test_version_read();
        test_fire_and_forget();
        test_backpressure();
        test_stream_read();
        test_timeout();
        test_reset_mid_send();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
